// File: rtl/vc_ram_stream_reader_pkg.sv
// Shared types for the RAM stream reader.
// Holds the controller state encoding.
package vc_ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/vc_ram_stream_reader_bitrev.sv
// Combinational bit-order reversal of an index.
// Shared with the FFT address generators.
module vc_ram_stream_reader_bitrev #(
  parameter int AW = 4
) (
  input  logic [AW-1:0] in_i,
  output logic [AW-1:0] out_o
);

  // Mirror every bit position.
  always_comb begin
    out_o = '0;
    for (int k = 0; k < AW; k++) begin
      out_o[k] = in_i[AW-1-k];
    end
  end

endmodule

// File: rtl/vc_ram_stream_reader.sv
// Streams a block of words out of a combinational-read RAM.
// Linear or bit-reversed order, registered val/rdy output.
module vc_ram_stream_reader
  import vc_ram_stream_reader_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_val,
  output logic          cmd_rdy,
  input  logic [AW-1:0] cmd_base,
  input  logic [AW:0]   cmd_len,
  input  logic          cmd_bitrev,
  output logic [AW-1:0] raddr,
  input  logic [W-1:0]  rdata,
  output logic          out_val,
  input  logic          out_rdy,
  output logic [W-1:0]  out_data,
  output logic          out_last,
  output logic          busy
);

  localparam logic [AW:0] MAXLEN = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [AW:0]   idx_q, idx_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] base_q, base_d;
  logic          rev_q, rev_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic          val_q, val_d;
  logic [W-1:0]  data_q, data_d;
  logic          last_q, last_d;

  logic [AW-1:0] idx_lo;
  logic [AW-1:0] idx_rev;
  logic [AW-1:0] offset;
  logic [AW-1:0] addr_nxt;
  logic          advance;
  logic          is_last;

  assign idx_lo   = idx_q[AW-1:0] + 1'b1;
  assign offset   = rev_q ? idx_rev : idx_lo;
  assign addr_nxt = base_q + offset;
  assign advance  = !val_q || out_rdy;
  assign is_last  = (idx_q == len_q - 1'b1);

  vc_ram_stream_reader_bitrev #(
    .AW(AW)
  ) u_bitrev (
    .in_i (idx_lo),
    .out_o(idx_rev)
  );

  // State, index, address and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      base_q  <= '0;
      rev_q   <= 1'b0;
      raddr_q <= '0;
      val_q   <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      base_q  <= base_d;
      rev_q   <= rev_d;
      raddr_q <= raddr_d;
      val_q   <= val_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  // Next-state: accept, read-and-capture, drain last word.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    base_d  = base_q;
    rev_d   = rev_q;
    raddr_d = raddr_q;
    val_d   = val_q;
    data_d  = data_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_val && cmd_len != '0) begin
          state_d = RUN;
          base_d  = cmd_base;
          len_d   = cmd_len;
          rev_d   = cmd_bitrev;
          idx_d   = '0;
          raddr_d = cmd_base;
        end
      end
      RUN: begin
        if (advance) begin
          data_d  = rdata;
          val_d   = 1'b1;
          last_d  = is_last;
          idx_d   = idx_q + 1'b1;
          raddr_d = addr_nxt;
          if (is_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (val_q && out_rdy) begin
          val_d   = 1'b0;
          last_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_rdy  = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign raddr    = raddr_q;
  assign out_val  = val_q;
  assign out_data = data_q;
  assign out_last = last_q;

  // Illegal length and unknown handshake inputs.
  a_len: assert property (@(posedge clk) disable iff (!reset_n)
    (cmd_val && cmd_rdy) |-> (cmd_len <= MAXLEN));
  a_cval: assert property (@(posedge clk) disable iff (!reset_n)
    !$isunknown(cmd_val));
  a_ordy: assert property (@(posedge clk) disable iff (!reset_n)
    val_q |-> !$isunknown(out_rdy));

endmodule

// File: tb/tb_vc_ram_stream_reader.sv
// Bench for the RAM stream reader.
// Queue model of expected words plus directed literal checks.
module tb_vc_ram_stream_reader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_val;
  logic       cmd_rdy;
  logic [3:0] cmd_base;
  logic [4:0] cmd_len;
  logic       cmd_bitrev;
  logic [3:0] raddr;
  logic [7:0] rdata;
  logic       out_val;
  logic       out_rdy;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  logic [7:0] mem [16];
  logic [8:0] exp_q [$];
  logic [7:0] got_d [$];
  logic       got_l [$];
  logic       rdy_rand = 1'b0;

  int checks = 0;
  int errors = 0;

  assign rdata = mem[raddr];

  vc_ram_stream_reader #(
    .W(8), .DEPTH(16), .AW(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .cmd_bitrev(cmd_bitrev),
    .raddr(raddr), .rdata(rdata),
    .out_val(out_val), .out_rdy(out_rdy),
    .out_data(out_data), .out_last(out_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] rev4(logic [3:0] i);
    return {i[0], i[1], i[2], i[3]};
  endfunction

  // Compare every valid output word to the model queue.
  always @(negedge clk) begin
    if (reset_n && out_val) begin
      if (exp_q.size() == 0) begin
        chk("spurious_val", 32'(out_data), 32'hFFFF);
      end else begin
        chk("mon_data", 32'(out_data), 32'(exp_q[0][7:0]));
        chk("mon_last", 32'(out_last), 32'(exp_q[0][8]));
        if (out_rdy) begin
          void'(exp_q.pop_front());
          got_d.push_back(out_data);
          got_l.push_back(out_last);
        end
      end
    end
  end

  // Random backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) out_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic send_cmd(int b, int l, int br);
    int n;
    @(posedge clk);
    #1;
    cmd_val    = 1'b1;
    cmd_base   = 4'(b);
    cmd_len    = 5'(l);
    cmd_bitrev = br[0];
    n = 0;
    forever begin
      @(negedge clk);
      if (cmd_rdy) break;
      n++;
      if (n > 500) begin
        chk("cmd_timeout", 32'(n), 32'd0);
        break;
      end
    end
    for (int i = 0; i < l; i++) begin
      logic [3:0] a;
      logic [3:0] o;
      o = br[0] ? rev4(4'(i)) : 4'(i);
      a = 4'(b) + o;
      exp_q.push_back({(i == l - 1), mem[a]});
    end
    @(posedge clk);
    #1;
    cmd_val = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
      n++;
      if (n > 1000) begin
        chk("idle_timeout", 32'(n), 32'd0);
        break;
      end
    end
  endtask

  task automatic chk_list(string nm, logic [7:0] e[$]);
    chk({nm, "_n"}, 32'(got_d.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < got_d.size(); i++)
      chk(nm, 32'(got_d[i]), 32'(e[i]));
  endtask

  task automatic clr();
    got_d.delete();
    got_l.delete();
  endtask

  initial begin
    logic [7:0] e[$];
    logic       pat [7];
    int         n;
    reset_n    = 1'b0;
    cmd_val    = 1'b0;
    cmd_base   = '0;
    cmd_len    = '0;
    cmd_bitrev = 1'b0;
    out_rdy    = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 8'hA5;

    #23;
    chk("rst_val", 32'(out_val), 0);
    chk("rst_rdy", 32'(cmd_rdy), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_raddr", 32'(raddr), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_last", 32'(out_last), 0);
    #4 reset_n = 1'b1;

    // 1: reset contents, cycle-exact timing
    clr();
    send_cmd(0, 4, 0);
    @(negedge clk);
    chk("t1_lat", 32'(out_val), 0);
    chk("t1_busy0", 32'(busy), 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_val", 32'(out_val), 1);
      chk("t1_data", 32'(out_data), 32'hA5);
      chk("t1_last", 32'(out_last), 32'(k == 3));
    end
    chk("t1_busy4", 32'(busy), 1);
    @(negedge clk);
    chk("t1_busyoff", 32'(busy), 0);
    chk("t1_cmdrdy", 32'(cmd_rdy), 1);
    chk("t1_valoff", 32'(out_val), 0);

    // 2: bit-reversed full block
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    clr();
    send_cmd(0, 16, 1);
    wait_idle();
    e = '{8'h0, 8'h8, 8'h4, 8'hC, 8'h2, 8'hA, 8'h6, 8'hE,
          8'h1, 8'h9, 8'h5, 8'hD, 8'h3, 8'hB, 8'h7, 8'hF};
    chk_list("t2_bitrev", e);

    // 3: wrap-around
    clr();
    send_cmd(14, 4, 0);
    wait_idle();
    e = '{8'hE, 8'hF, 8'h0, 8'h1};
    chk_list("t3_wrap", e);

    // 4: backpressure and stalled second command
    clr();
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    send_cmd(0, 4, 0);
    fork
      begin
        for (int i = 0; i < 7; i++) begin
          out_rdy = pat[i];
          @(posedge clk);
          #1;
        end
        out_rdy = 1'b1;
      end
    join_none
    send_cmd(8, 2, 0);
    chk("t4_held", 32'(got_d.size()), 4);
    wait_idle();
    e = '{8'h0, 8'h1, 8'h2, 8'h3, 8'h8, 8'h9};
    chk_list("t4_bp", e);

    // 5: zero length, then single word
    clr();
    send_cmd(5, 0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t5_noval", 32'(out_val), 0);
      chk("t5_rdy", 32'(cmd_rdy), 1);
    end
    send_cmd(3, 1, 0);
    wait_idle();
    e = '{8'h3};
    chk_list("t5_one", e);
    if (got_l.size() > 0)
      chk("t5_last", 32'(got_l[0]), 1);

    // 6: reset mid-block
    clr();
    send_cmd(0, 8, 0);
    n = 0;
    while (got_d.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_progress", 32'(got_d.size() >= 2), 1);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_val", 32'(out_val), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_rdy", 32'(cmd_rdy), 1);
    exp_q.delete();
    @(posedge clk);
    #2 reset_n = 1'b1;
    clr();
    send_cmd(0, 2, 0);
    wait_idle();
    e = '{8'h0, 8'h1};
    chk_list("t6_after", e);

    // random commands, contents and backpressure
    rdy_rand = 1'b1;
    for (int r = 0; r < 40; r++) begin
      if (r % 10 == 0) begin
        wait_idle();
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      end
      send_cmd($urandom_range(0, 15), $urandom_range(0, 16),
               $urandom_range(0, 1));
    end
    wait_idle();
    rdy_rand = 1'b0;
    out_rdy  = 1'b1;
    chk("rnd_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
